// File: rtl/cpu_step_sequencer.sv
// Multi-cycle step sequencer for the 16-bit CPU core: instruction/flag/PC strobes and loader arbitration.
// Optional instruction-limit watchdog is built when CPU_STEP_WATCHDOG_EN is defined.
module cpu_step_sequencer #(
    parameter int unsigned      EXEC_CYC = 2,
    parameter int unsigned      CNT_W    = 16,
    parameter logic [CNT_W-1:0] MAX_INS  = CNT_W'(16'hFFFF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             done,
    input  logic             ext_req,
    input  logic [7:0]       ext_addr,
    input  logic [15:0]      ext_data,
    output logic             ext_ack,
    output logic             ext_mem_wen,
    output logic [7:0]       ext_mem_addr,
    output logic [15:0]      ext_mem_data,
    output logic             ins_en,
    output logic             flag_en,
    output logic             step,
    output logic             busy,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_FLAG  = 3'd4;
    localparam logic [2:0] S_STEP  = 3'd5;
    localparam logic [2:0] S_PAUSE = 3'd6;
    localparam logic [2:0] S_HALT  = 3'd7;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] retired_inc;
    logic             step_btn_q;
    logic             btn_rise;

`ifdef CPU_STEP_WATCHDOG_EN
    logic timeout_q, timeout_d;
`else
    logic unused_max_ins;
    assign unused_max_ins = ^MAX_INS;
`endif

    assign btn_rise    = step_btn & ~step_btn_q;
    assign retired_inc = (retired_q == '1) ? retired_q : retired_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        exec_cnt_d = exec_cnt_q;
        retired_d  = retired_q;
`ifdef CPU_STEP_WATCHDOG_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ext_req) begin
                    state_d = S_LOAD;
                end else if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_LOAD: state_d = S_IDLE;
            S_FETCH: begin
                state_d    = S_EXEC;
                exec_cnt_d = '0;
            end
            S_EXEC: begin
                exec_cnt_d = exec_cnt_q + 4'd1;
                if (exec_cnt_q == EXEC_LAST) begin
                    state_d = S_FLAG;
                end
            end
            S_FLAG: state_d = done ? S_HALT : S_STEP;
            S_STEP: begin
                retired_d = retired_inc;
                state_d   = run_mode ? S_FETCH : S_PAUSE;
`ifdef CPU_STEP_WATCHDOG_EN
                if (retired_inc == MAX_INS) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end
`endif
            end
            // ext_req is deliberately ignored here: the core still owns memory while paused
            S_PAUSE: begin
                if (btn_rise || run_mode) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (ext_req || start) begin
                    state_d   = ext_req ? S_LOAD : S_IDLE;
                    retired_d = '0;
`ifdef CPU_STEP_WATCHDOG_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            exec_cnt_q   <= '0;
            retired_q    <= '0;
            step_btn_q   <= 1'b0;
            ext_mem_addr <= '0;
            ext_mem_data <= '0;
        end else begin
            state_q    <= state_d;
            exec_cnt_q <= exec_cnt_d;
            retired_q  <= retired_d;
            step_btn_q <= step_btn;
            if (state_d == S_LOAD) begin
                ext_mem_addr <= ext_addr;
                ext_mem_data <= ext_data;
            end
        end
    end

`ifdef CPU_STEP_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Strobes are flops decoded from the next state, so they line up with state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_en      <= 1'b0;
            flag_en     <= 1'b0;
            step        <= 1'b0;
            ext_mem_wen <= 1'b0;
            ext_ack     <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            ins_en      <= (state_d == S_FETCH);
            flag_en     <= (state_d == S_FLAG);
            step        <= (state_d == S_STEP);
            ext_mem_wen <= (state_d == S_LOAD);
            ext_ack     <= (state_d == S_LOAD);
            busy        <= (state_d inside {S_FETCH, S_EXEC, S_FLAG, S_STEP, S_PAUSE});
            halted      <= (state_d == S_HALT);
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed scoreboard bench for cpu_step_sequencer (EXEC_CYC = 2).
module tb_cpu_step_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_FLAG  = 3'd4;
    localparam logic [2:0] S_STEP  = 3'd5;
    localparam logic [2:0] S_PAUSE = 3'd6;
    localparam logic [2:0] S_HALT  = 3'd7;

`ifdef CPU_STEP_WATCHDOG_EN
    localparam logic [15:0] MAX_INS_TB = 16'd4;
`else
    localparam logic [15:0] MAX_INS_TB = 16'hFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        run_mode = 1'b0;
    logic        step_btn = 1'b0;
    logic        done = 1'b0;
    logic        ext_req = 1'b0;
    logic [7:0]  ext_addr = '0;
    logic [15:0] ext_data = '0;
    logic        ext_ack, ext_mem_wen, ins_en, flag_en, step, busy, halted, timeout;
    logic [7:0]  ext_mem_addr;
    logic [15:0] ext_mem_data;
    logic [15:0] retired;
    logic [2:0]  state;

    always #5 clk = ~clk;

    cpu_step_sequencer #(
        .EXEC_CYC(2),
        .CNT_W   (16),
        .MAX_INS (MAX_INS_TB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .run_mode    (run_mode),
        .step_btn    (step_btn),
        .done        (done),
        .ext_req     (ext_req),
        .ext_addr    (ext_addr),
        .ext_data    (ext_data),
        .ext_ack     (ext_ack),
        .ext_mem_wen (ext_mem_wen),
        .ext_mem_addr(ext_mem_addr),
        .ext_mem_data(ext_mem_data),
        .ins_en      (ins_en),
        .flag_en     (flag_en),
        .step        (step),
        .busy        (busy),
        .halted      (halted),
        .timeout     (timeout),
        .retired     (retired),
        .state       (state)
    );

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic       exp_to = 1'b0;

    // {ins_en, flag_en, step, ext_mem_wen, ext_ack, busy, halted} implied by a state
    function automatic logic [6:0] strobes_for(input logic [2:0] s);
        logic bz;
        bz = (s == S_FETCH) || (s == S_EXEC) || (s == S_FLAG) || (s == S_STEP) || (s == S_PAUSE);
        return {s == S_FETCH, s == S_FLAG, s == S_STEP, s == S_LOAD, s == S_LOAD, bz, s == S_HALT};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic push_instr(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(S_FETCH);
            exp_q.push_back(S_EXEC);
            exp_q.push_back(S_EXEC);
            exp_q.push_back(S_FLAG);
            exp_q.push_back(S_STEP);
        end
    endtask

    task automatic push_n(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endtask

    task automatic tick_check(input string tag, input int n);
        logic [2:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_state"}, 32'(state), 32'(e));
                check({tag, "_strobes"},
                      32'({ins_en, flag_en, step, ext_mem_wen, ext_ack, busy, halted}),
                      32'(strobes_for(e)));
                check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        start = 1'b0; run_mode = 1'b0; step_btn = 1'b0; done = 1'b0;
        ext_req = 1'b0; ext_addr = '0; ext_data = '0;
        exp_to = 1'b0;
        #1;
        check({tag, "_rst_state"}, 32'(state), 32'(S_IDLE));
        check({tag, "_rst_strobes"},
              32'({ins_en, flag_en, step, ext_mem_wen, ext_ack, busy, halted}), 32'd0);
        check({tag, "_rst_retired"}, 32'(retired), 32'd0);
        check({tag, "_rst_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_rst_memaddr"}, 32'({ext_mem_addr, ext_mem_data}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        do_reset("init");

        // Free run: ins_en @1, flag_en @4, step @5, ins_en @6
        start = 1'b1; run_mode = 1'b1;
        push_instr(3);
        push_n(S_FETCH, 1); push_n(S_EXEC, 2);
        tick_check("free", 1);
        start = 1'b0;
        tick_check("free", 17);
        check("free_retired", 32'(retired), 32'd3);

        // Reset while sitting in EXEC
        check("midexec_state", 32'(state), 32'(S_EXEC));
        do_reset("midexec");
        push_n(S_IDLE, 3);
        tick_check("postrst", 3);
        check("postrst_retired", 32'(retired), 32'd0);

        // Halt on done in the third FLAG
        start = 1'b1; run_mode = 1'b1;
        push_instr(2);
        push_n(S_FETCH, 1); push_n(S_EXEC, 2); push_n(S_FLAG, 1); push_n(S_HALT, 2);
        tick_check("halt", 1);
        start = 1'b0;
        tick_check("halt", 12);
        done = 1'b1;
        tick_check("halt", 2);
        done = 1'b0;
        check("halt_retired", 32'(retired), 32'd2);
        tick_check("halt", 1);
        start = 1'b1;
        push_n(S_IDLE, 2);
        tick_check("unhalt", 1);
        start = 1'b0;
        check("unhalt_retired", 32'(retired), 32'd0);
        tick_check("unhalt", 1);

        // Single step
        do_reset("sstep");
        start = 1'b1; run_mode = 1'b0;
        push_instr(1); push_n(S_PAUSE, 3);
        tick_check("sstep", 1);
        start = 1'b0;
        tick_check("sstep", 7);
        check("sstep_retired1", 32'(retired), 32'd1);
        ext_req = 1'b1; ext_addr = 8'h11;
        push_n(S_PAUSE, 2);
        tick_check("pause_req", 2);
        ext_req = 1'b0;
        step_btn = 1'b1;
        push_instr(1); push_n(S_PAUSE, 4);
        tick_check("btn_hold", 9);
        check("sstep_retired2", 32'(retired), 32'd2);
        step_btn = 1'b0;
        push_n(S_PAUSE, 1);
        tick_check("btn_low", 1);
        step_btn = 1'b1; ext_req = 1'b1;
        push_instr(1); push_n(S_PAUSE, 1);
        tick_check("btn_busyreq", 6);
        ext_req = 1'b0; step_btn = 1'b0;
        check("sstep_retired3", 32'(retired), 32'd3);
        check("sstep_nowrite", 32'(ext_mem_addr), 32'd0);
        run_mode = 1'b1;
        push_n(S_FETCH, 1); push_n(S_EXEC, 2); push_n(S_FLAG, 1); push_n(S_HALT, 1);
        tick_check("runhigh", 3);
        done = 1'b1;
        tick_check("runhigh", 2);
        done = 1'b0;

        // Loader wins over start in IDLE; no write while busy; reload from HALT
        do_reset("load");
        ext_req = 1'b1; ext_addr = 8'h3C; ext_data = 16'hA5F0; start = 1'b1; run_mode = 1'b1;
        push_n(S_LOAD, 1);
        tick_check("load", 1);
        check("load_addr", 32'(ext_mem_addr), 32'h3C);
        check("load_data", 32'(ext_mem_data), 32'hA5F0);
        ext_req = 1'b0;
        push_n(S_IDLE, 1); push_n(S_FETCH, 1);
        tick_check("load_ret", 2);
        start = 1'b0;
        ext_req = 1'b1; ext_addr = 8'h55; ext_data = 16'h1234;
        push_n(S_EXEC, 2); push_n(S_FLAG, 1); push_n(S_STEP, 1); push_n(S_FETCH, 1);
        push_n(S_EXEC, 2); push_n(S_FLAG, 1); push_n(S_HALT, 1); push_n(S_LOAD, 1);
        tick_check("busyreq", 7);
        check("busyreq_addr", 32'({ext_mem_addr, ext_mem_data}), 32'h3CA5F0);
        done = 1'b1;
        tick_check("busyreq", 2);
        done = 1'b0;
        check("reload_retired_pre", 32'(retired), 32'd1);
        tick_check("reload", 1);
        ext_req = 1'b0;
        check("reload_addr", 32'({ext_mem_addr, ext_mem_data}), 32'h551234);
        check("reload_retired", 32'(retired), 32'd0);
        push_n(S_IDLE, 1);
        tick_check("reload_ret", 1);

        // Instruction limit
        do_reset("wdog");
        start = 1'b1; run_mode = 1'b1;
        push_instr(4);
`ifdef CPU_STEP_WATCHDOG_EN
        push_n(S_HALT, 4);
        tick_check("wdog", 1);
        start = 1'b0;
        tick_check("wdog", 19);
        exp_to = 1'b1;
        tick_check("wdog_trip", 4);
        check("wdog_retired", 32'(retired), 32'd4);
        start = 1'b1;
        exp_to = 1'b0;
        push_n(S_IDLE, 1);
        tick_check("wdog_clear", 1);
        start = 1'b0;
        check("wdog_clear_retired", 32'(retired), 32'd0);
`else
        push_n(S_FETCH, 1);
        tick_check("nolimit", 1);
        start = 1'b0;
        tick_check("nolimit", 20);
        check("nolimit_retired", 32'(retired), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
